// File: rtl/wb_regfile_pkg.sv
// Shared write-back pipeline constants: source-select encodings and sizes.
package wb_regfile_pkg;

  localparam int XLEN    = 32;
  localparam int NREGS   = 32;
  localparam int AW      = 5;

  // Write-back source select. Encoding 2'b11 is treated as ALU.
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

endpackage

// File: rtl/wb_regfile_regfile32.sv
// 32 x 32 register storage: one synchronous write port, three combinational
// read ports, synchronous active-low clear. Register 0 is hardwired to zero.
module regfile32
  import wb_regfile_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic [AW-1:0]   ra3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [XLEN-1:0] rd3
);

  logic [XLEN-1:0] mem [NREGS];

  // Clear on reset (reset wins over a write); otherwise commit the write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // Combinational reads; address 0 always returns zero.
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : mem[ra1];
    rd2 = (ra2 == '0) ? '0 : mem[ra2];
    rd3 = (ra3 == '0) ? '0 : mem[ra3];
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage with register file: selects the write-back value,
// writes it to storage, forwards it to the read ports in the same cycle,
// and counts committed register writes.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     ddpc4,
  input  logic [31:0]     dbusw,
  input  logic [31:0]     ddata,
  input  logic [4:0]      drw,
  input  logic            nnnreg_write,
  input  logic [1:0]      nnns_data_write,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      dbg_ra,
  output logic [31:0]     rd1,
  output logic [31:0]     rd2,
  output logic [31:0]     dbg_rd,
  output logic [31:0]     wb_data,
  output logic [4:0]      wb_rw,
  output logic            wb_we,
  output logic [31:0]     wb_count
);

  logic [31:0] st_rd1;
  logic [31:0] st_rd2;
  logic [31:0] count_q;

  // Write-back source mux and effective write enable (r0 writes suppressed).
  always_comb begin
    unique case (nnns_data_write)
      WB_SEL_MEM:  wb_data = ddata;
      WB_SEL_LINK: wb_data = ddpc4;
      default:     wb_data = dbusw;
    endcase
    wb_we = nnnreg_write && (drw != 5'd0);
    wb_rw = drw;
  end

  regfile32 u_rf (
    .clock (clock),
    .reset (reset),
    .we    (wb_we),
    .wa    (drw),
    .wd    (wb_data),
    .ra1   (ra1),
    .ra2   (ra2),
    .ra3   (dbg_ra),
    .rd1   (st_rd1),
    .rd2   (st_rd2),
    .rd3   (dbg_rd)
  );

  // Write-through bypass; wb_we already excludes r0 so address 0 reads 0.
  always_comb begin
    rd1 = (wb_we && (ra1 == drw)) ? wb_data : st_rd1;
    rd2 = (wb_we && (ra2 == drw)) ? wb_data : st_rd2;
  end

  // Committed-write counter, cleared by reset, wraps naturally.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else if (wb_we) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign wb_count = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios followed by randomized traffic,
// compared against an architectural register-file model.
module tb_wb_regfile;

  logic        clock;
  logic        reset;
  logic [31:0] ddpc4, dbusw, ddata;
  logic [4:0]  drw, ra1, ra2, dbg_ra;
  logic        nnnreg_write;
  logic [1:0]  nnns_data_write;
  logic [31:0] rd1, rd2, dbg_rd, wb_data, wb_count;
  logic [4:0]  wb_rw;
  logic        wb_we;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [31:0] ref_regs [32];
  logic [31:0] ref_count;
  logic [31:0] exp_q [$];

  wb_regfile dut (
    .clock           (clock),
    .reset           (reset),
    .ddpc4           (ddpc4),
    .dbusw           (dbusw),
    .ddata           (ddata),
    .drw             (drw),
    .nnnreg_write    (nnnreg_write),
    .nnns_data_write (nnns_data_write),
    .ra1             (ra1),
    .ra2             (ra2),
    .dbg_ra          (dbg_ra),
    .rd1             (rd1),
    .rd2             (rd2),
    .dbg_rd          (dbg_rd),
    .wb_data         (wb_data),
    .wb_rw           (wb_rw),
    .wb_we           (wb_we),
    .wb_count        (wb_count)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (limit 2000000)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: value the instruction writes back, by select rule.
  function automatic logic [31:0] m_data();
    case (nnns_data_write)
      2'b01:   return ddata;
      2'b10:   return ddpc4;
      default: return dbusw;
    endcase
  endfunction

  function automatic logic m_we();
    return nnnreg_write && (drw != 5'd0);
  endfunction

  // Architectural read: r0 is zero, a write in this cycle is visible.
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_we() && a == drw) return m_data();
    return ref_regs[a];
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    ref_count = 32'd0;
  endfunction

  // Driver: idle inputs
  task automatic idle();
    nnnreg_write = 1'b0; nnns_data_write = 2'b00;
    drw = 5'd0; ra1 = 5'd0; ra2 = 5'd0; dbg_ra = 5'd0;
    ddpc4 = 32'd0; dbusw = 32'd0; ddata = 32'd0;
  endtask

  // Let inputs settle and compare every combinational output to the model.
  task automatic settle();
    #2;
    check("wb_data", wb_data, m_data());
    check("wb_we", {31'd0, wb_we}, {31'd0, m_we()});
    check("wb_rw", {27'd0, wb_rw}, {27'd0, drw});
    check("rd1", rd1, m_read(ra1));
    check("rd2", rd2, m_read(ra2));
    check("dbg_rd", dbg_rd, (dbg_ra == 5'd0) ? 32'd0 : ref_regs[dbg_ra]);
  endtask

  // Apply the clock edge to the model and DUT, then check the counter.
  task automatic commit();
    if (!reset) m_reset();
    else if (m_we()) begin
      ref_regs[drw] = m_data();
      ref_count = ref_count + 32'd1;
    end
    @(posedge clock);
    #1;
    check("wb_count", wb_count, ref_count);
  endtask

  task automatic cycle();
    settle();
    commit();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'hx;
    ref_count = 32'hx;
    @(posedge clock); #1;

    // Reset: two cycles low, then sweep every debug address
    m_reset();
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    check("reset_count", wb_count, 32'd0);
    for (int a = 0; a < 32; a++) begin
      dbg_ra = 5'(a);
      #1;
      check("reset_dbg", dbg_rd, 32'd0);
    end
    idle();

    // Source select MEM with same-cycle bypass
    nnns_data_write = 2'b01; ddata = 32'hDEADBEEF; drw = 5'd5;
    nnnreg_write = 1'b1; ra1 = 5'd5;
    settle();
    check("mem_bypass_rd1", rd1, 32'hDEADBEEF);
    commit();
    exp_q.push_back(32'hDEADBEEF);
    idle(); dbg_ra = 5'd5;
    settle();
    check("mem_dbg", dbg_rd, exp_q.pop_front());
    check("mem_count", wb_count, 32'd1);
    commit();

    // Link write to r31, then select 11 falls back to ALU
    idle(); nnns_data_write = 2'b10; ddpc4 = 32'h00400008; drw = 5'd31;
    nnnreg_write = 1'b1; dbusw = 32'h77;
    cycle();
    exp_q.push_back(32'h00400008);
    idle(); dbg_ra = 5'd31;
    settle();
    check("link_dbg", dbg_rd, exp_q.pop_front());
    commit();
    idle(); nnns_data_write = 2'b11; dbusw = 32'h12; ddata = 32'h99;
    ddpc4 = 32'h44; drw = 5'd31; nnnreg_write = 1'b1; ra2 = 5'd31;
    dbg_ra = 5'd31;
    settle();
    check("sel11_dbg_nobypass", dbg_rd, 32'h00400008);
    commit();
    exp_q.push_back(32'h12);
    idle(); dbg_ra = 5'd31;
    settle();
    check("sel11_dbg", dbg_rd, exp_q.pop_front());
    commit();

    // r0 protection
    idle(); nnnreg_write = 1'b1; drw = 5'd0; dbusw = 32'hFFFFFFFF;
    settle();
    check("r0_rd1", rd1, 32'd0);
    check("r0_rd2", rd2, 32'd0);
    check("r0_we", {31'd0, wb_we}, 32'd0);
    commit();
    check("r0_count", wb_count, 32'd3);

    // Reset collides with a write: reset wins
    idle(); reset = 1'b0; nnnreg_write = 1'b1; drw = 5'd7; dbusw = 32'h55;
    ra1 = 5'd7;
    cycle();
    reset = 1'b1;
    idle(); dbg_ra = 5'd7;
    settle();
    check("coll_dbg", dbg_rd, 32'd0);
    check("coll_count", wb_count, 32'd0);
    commit();

    // Counter wrap-around via a forced preload
    @(negedge clock);
    force dut.count_q = 32'hFFFFFFFF;
    #1;
    release dut.count_q;
    @(posedge clock); #1;
    ref_count = 32'hFFFFFFFF;
    check("wrap_preload", wb_count, 32'hFFFFFFFF);
    idle(); nnnreg_write = 1'b1; drw = 5'd9; dbusw = 32'hA5A5;
    cycle();
    check("wrap_zero", wb_count, 32'd0);

    // Randomized traffic with narrow address ranges to exercise bypass
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 24) != 0);
      nnnreg_write = ($urandom_range(0, 3) != 0);
      nnns_data_write = 2'($urandom_range(0, 3));
      ddpc4 = $urandom(); dbusw = $urandom(); ddata = $urandom();
      drw = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 7));
      dbg_ra = ($urandom_range(0, 3) == 0) ? drw : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) drw = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the ports SHALL be named clock and reset.
REQ-002 The port list SHALL be, one per line: name, direction, width, meaning.
- clock  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset
- ddpc4  input  32  PC+4 of the retiring instruction (link value)
- dbusw  input  32  ALU result
- ddata  input  32  data-memory load result
- drw  input  5  destination register number
- nnnreg_write  input  1  register write enable
- nnns_data_write  input  2  write-back source select
- ra1  input  5  read address, port 1
- ra2  input  5  read address, port 2
- dbg_ra  input  5  debug read address
- rd1  output  32  read data, port 1
- rd2  output  32  read data, port 2
- dbg_rd  output  32  debug read data (no bypass)
- wb_data  output  32  selected write-back value
- wb_rw  output  5  destination register being written
- wb_we  output  1  effective write enable
- wb_count  output  32  count of committed register writes

Function
REQ-003 wb_data SHALL be combinational from the source select: 00 gives dbusw, 01 gives ddata, 10 gives ddpc4, 11 gives dbusw.
REQ-004 wb_we SHALL equal nnnreg_write AND (drw != 0), and wb_rw SHALL equal drw; both SHALL be combinational.
REQ-005 The block SHALL hold 32 registers of 32 bits; register 0 SHALL always read 0 and SHALL never be written.
REQ-006 On a rising clock edge with reset=1 and wb_we=1, register[drw] SHALL take wb_data, so the write is visible in storage on the next cycle.
REQ-007 rd1 and rd2 SHALL be combinational reads of the stored registers.
REQ-008 Write-through bypass: when wb_we=1 and ra1==drw, rd1 SHALL equal wb_data in the same cycle; the same rule SHALL apply to rd2 with ra2.
REQ-009 A read address of 0 SHALL return 0 even when nnnreg_write=1 and drw=0.
REQ-010 dbg_rd SHALL return the stored value only, with no bypass.
REQ-011 wb_count SHALL increment by 1 on each edge where wb_we=1 and reset=1, and SHALL wrap from FFFFFFFF to 0.
REQ-012 When ra1 and ra2 equal each other and equal drw, both ports SHALL return the same bypassed value.
REQ-013 Write-back latency SHALL be 0 cycles to rd1 and rd2 through the bypass, and 1 cycle to storage and to dbg_rd.

Reset
REQ-014 On a rising edge with reset=0, all 32 registers and wb_count SHALL become 0.
REQ-015 Reset SHALL take priority over a write in the same cycle, and that write SHALL be discarded.
REQ-016 While reset=0, the outputs rd1, rd2 and dbg_rd SHALL reflect the stored zeros plus any REQ-008 bypass; wb_data, wb_rw and wb_we SHALL stay combinational.
REQ-017 If reset is asserted while a write is in flight, that write SHALL NOT be committed, and wb_count SHALL NOT count it.

Structure
REQ-018 The source-select encodings WB_SEL_ALU=00, WB_SEL_MEM=01 and WB_SEL_LINK=10 SHALL live in the shared include file of pipeline constants.
REQ-019 The register storage SHALL be a sub-module named regfile32, with one write port, three combinational read ports and reset.
REQ-020 The select mux, bypass logic and counter SHALL reside in wb_regfile.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset: hold reset=0 for 2 cycles, then read every address on dbg_ra → every dbg_rd = 0 and wb_count = 0.
- Source select: nnns_data_write=01, ddata=0xDEADBEEF, drw=5, nnnreg_write=1, with ra1=5 in the same cycle → rd1 = 0xDEADBEEF; next cycle dbg_ra=5 → dbg_rd = 0xDEADBEEF and wb_count = 1.
- Link write: nnns_data_write=10, ddpc4=0x00400008, drw=31 → register 31 = 0x00400008; repeat with select 11 and dbusw=0x12 → register 31 = 0x12.
- r0 protection: nnnreg_write=1, drw=0, dbusw=0xFFFFFFFF, ra1=ra2=0 → rd1 = rd2 = 0, wb_we = 0, wb_count unchanged.
- Reset collision: reset=0 together with a write of 0x55 to register 7 → register 7 = 0 and wb_count = 0.
- Wrap-around: preload wb_count to 0xFFFFFFFF through 2^32-1 writes or a force, then one more write → wb_count = 0.
